// File: rtl/dma_ddr_bank_switch_ctrl_if.sv
// Handshake bundle between the DMA engine, the DDR bank selector and the
// bank-switch controller: bank request, AR/AW gating pairs and the monitored
// R/B response channels.
interface dma_ddr_bank_switch_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             req_valid;
  logic [SEL_W-1:0] req_bank;
  logic             req_ready;
  logic             bank_err;

  logic             src_arvalid;
  logic             src_arready;
  logic             mem_arvalid;
  logic             mem_arready;

  logic             src_awvalid;
  logic             src_awready;
  logic             mem_awvalid;
  logic             mem_awready;

  logic             rvalid;
  logic             rready;
  logic             rlast;
  logic             bvalid;
  logic             bready;

  // Controller side
  modport slave (
    input  req_valid, req_bank,
    input  src_arvalid, mem_arready,
    input  src_awvalid, mem_awready,
    input  rvalid, rready, rlast,
    input  bvalid, bready,
    output req_ready, bank_err,
    output src_arready, mem_arvalid,
    output src_awready, mem_awvalid
  );

  // Engine / selector side
  modport master (
    output req_valid, req_bank,
    output src_arvalid, mem_arready,
    output src_awvalid, mem_awready,
    output rvalid, rready, rlast,
    output bvalid, bready,
    input  req_ready, bank_err,
    input  src_arready, mem_arvalid,
    input  src_awready, mem_awvalid
  );
endinterface

// File: rtl/dma_ddr_bank_switch_ctrl.sv
// Bank-switch sequencer in front of the DMA DDR bank selector.
// Owns bank_sel and only changes it once every outstanding AXI read and write
// on the current bank has completed; new AR/AW issue is held off while a
// switch is pending so no burst straddles two banks.
// Optional drain watchdog: define DMA_DDR_SWITCH_TIMEOUT_EN to build it;
// otherwise drain_timeout is tied low.
module dma_ddr_bank_switch_ctrl #(
  parameter int NUM_LOCAL_MEM_BANKS = 4,
  parameter int MAX_OUTSTANDING     = 64,
  parameter int DRAIN_TIMEOUT       = 4096,
  localparam int SEL_W = ($clog2(NUM_LOCAL_MEM_BANKS) > 1) ? $clog2(NUM_LOCAL_MEM_BANKS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  dma_ddr_bank_switch_ctrl_if.slave  bus,
  output logic [SEL_W-1:0]           bank_sel,
  output logic                       busy,
  output logic                       drain_timeout
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_OUTSTANDING);
  // One extra bit so a fully populated select range still compares cleanly.
  localparam logic [SEL_W:0] NUM_BANKS = (SEL_W + 1)'(NUM_LOCAL_MEM_BANKS);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] req_bank;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             gate_rd;
  logic             gate_wr;
  logic             ar_hs;
  logic             aw_hs;
  logic             r_done;
  logic             b_done;
  logic             req_in_range;
  logic             req_ready;
  logic             bank_err;
  logic             load_target;
  logic             load_sel;

  // In-flight counter update: a handshake and a completion in the same cycle
  // cancel; a completion with nothing outstanding is dropped (no underflow).
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  assign req_bank     = bus.req_bank;
  assign req_in_range = {1'b0, req_bank} < NUM_BANKS;

  // Issue gates: open only in ACTIVE and below the per-direction cap. W is
  // deliberately not gated since the bank is held until every B returns.
  assign gate_rd = (state == ACTIVE) && (rd_cnt < CNT_CAP);
  assign gate_wr = (state == ACTIVE) && (wr_cnt < CNT_CAP);

  assign bus.mem_arvalid = bus.src_arvalid & gate_rd;
  assign bus.src_arready = bus.mem_arready & gate_rd;
  assign bus.mem_awvalid = bus.src_awvalid & gate_wr;
  assign bus.src_awready = bus.mem_awready & gate_wr;

  assign ar_hs  = bus.mem_arvalid & bus.mem_arready;
  assign aw_hs  = bus.mem_awvalid & bus.mem_awready;
  assign r_done = bus.rvalid & bus.rready & bus.rlast;
  assign b_done = bus.bvalid & bus.bready;

  assign bus.req_ready = req_ready;
  assign bus.bank_err  = bank_err;

  // Next-state and request-acceptance decode.
  always_comb begin
    nxt_state   = state;
    req_ready   = 1'b0;
    bank_err    = 1'b0;
    load_target = 1'b0;
    load_sel    = 1'b0;
    case (state)
      ACTIVE: begin
        if (bus.req_valid) begin
          if (!req_in_range) begin
            req_ready = 1'b1;
            bank_err  = 1'b1;
          end else if (req_bank == bank_sel) begin
            req_ready = 1'b1;
          end else begin
            load_target = 1'b1;
            nxt_state   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((rd_cnt == '0) && (wr_cnt == '0)) begin
          load_sel  = 1'b1;
          nxt_state = SWITCH;
        end
      end
      SWITCH: begin
        req_ready = 1'b1;
        nxt_state = ACTIVE;
      end
      default: nxt_state = ACTIVE;
    endcase
  end

  // State, bank select and pending target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACTIVE;
      busy     <= 1'b0;
      bank_sel <= '0;
      target   <= '0;
    end else begin
      state <= nxt_state;
      busy  <= (nxt_state != ACTIVE);
      if (load_target) begin
        target <= req_bank;
      end
      if (load_sel) begin
        bank_sel <= target;
      end
    end
  end

  // Outstanding read/write transaction counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      rd_cnt <= cnt_next(rd_cnt, ar_hs, r_done);
      wr_cnt <= cnt_next(wr_cnt, aw_hs, b_done);
    end
  end

`ifdef DMA_DDR_SWITCH_TIMEOUT_EN
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(DRAIN_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

  logic [TO_W-1:0] drain_cnt;
  logic            timeout_flag;

  // Drain watchdog: restarts on every DRAIN entry, flags once the limit is
  // reached and stays flagged; the FSM keeps waiting regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (load_target) begin
        drain_cnt <= '0;
      end else if ((state == DRAIN) && (drain_cnt != TO_LIMIT)) begin
        drain_cnt <= drain_cnt + TO_W'(1);
      end
      if ((state == DRAIN) && (drain_cnt == TO_LAST)) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign drain_timeout = timeout_flag;
`else
  // No watchdog built; the parameter is still referenced so both builds share
  // one parameter list. Constant 0 for any legal DRAIN_TIMEOUT.
  assign drain_timeout = 1'b0 & (DRAIN_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_dma_ddr_bank_switch_ctrl.sv
// Bench for dma_ddr_bank_switch_ctrl: 5 banks (3-bit select so out-of-range
// indices are representable), 4 outstanding per direction, 16-cycle watchdog.
module tb_dma_ddr_bank_switch_ctrl;
  localparam int NB = 5;
  localparam int MO = 4;
  localparam int DT = 16;
  localparam int SW = 3;

  typedef struct {
    logic [SW-1:0] sel;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] bank_sel;
  logic          busy;
  logic          drain_timeout;

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic [SW-1:0] model_sel;

  dma_ddr_bank_switch_ctrl_if #(.SEL_W(SW)) bus ();

  dma_ddr_bank_switch_ctrl #(
    .NUM_LOCAL_MEM_BANKS(NB),
    .MAX_OUTSTANDING(MO),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .bank_sel(bank_sel),
    .busy(busy),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Scoreboard consumer: every accepted request pops its expected outcome.
  always @(negedge clk) begin
    if (!reset && bus.req_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_accept: req_ready=1 with no request pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bank_sel !== e.sel || bus.bank_err !== e.err) begin
          bad++;
          $display("FAIL sb_accept: bank_sel=%0d bank_err=%0b expected bank_sel=%0d bank_err=%0b",
                   bank_sel, bus.bank_err, e.sel, e.err);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_drive(input int bank);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_bank  = SW'(bank);
    e.err = (bank >= NB);
    if (bank < NB) model_sel = SW'(bank);
    e.sel = model_sel;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_bank    = '0;
    bus.src_arvalid = 1'b0;
    bus.mem_arready = 1'b0;
    bus.src_awvalid = 1'b0;
    bus.mem_awready = 1'b0;
    bus.rvalid      = 1'b0;
    bus.rready      = 1'b0;
    bus.rlast       = 1'b0;
    bus.bvalid      = 1'b0;
    bus.bready      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (bank_sel !== 3'd0) begin bad++; $display("FAIL reset_bank_sel: got %0d want 0", bank_sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b want 0", bus.req_ready); end
    total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %0b want 0", drain_timeout); end
    next_cyc();
    bus.src_arvalid = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_arvalid !== 1'b1 || bus.src_arready !== 1'b0) begin
      bad++; $display("FAIL reset_gate_open: mem_arvalid=%0b src_arready=%0b want 1/0", bus.mem_arvalid, bus.src_arready);
    end
    bus.src_arvalid = 1'b0;
  endtask

  task automatic test_same_bank();
    next_cyc();
    req_drive(0);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL same_bank_ready: req_ready=%0b busy=%0b want 1/0", bus.req_ready, busy);
    end
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bank_sel !== 3'd0) begin bad++; $display("FAIL same_bank_sel: got %0d want 0", bank_sel); end
  endtask

  task automatic test_switch_idle();
    next_cyc();
    req_drive(2);
    bus.src_arvalid = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0 || busy !== 1'b0 || bus.mem_arvalid !== 1'b1) begin
      bad++; $display("FAIL idle_sw_n: req_ready=%0b busy=%0b mem_arvalid=%0b want 0/0/1", bus.req_ready, busy, bus.mem_arvalid);
    end
    next_cyc();
    @(negedge clk);
    total++; if (busy !== 1'b1 || bus.mem_arvalid !== 1'b0 || bus.req_ready !== 1'b0 || bank_sel !== 3'd0) begin
      bad++; $display("FAIL idle_sw_n1: busy=%0b mem_arvalid=%0b req_ready=%0b bank_sel=%0d want 1/0/0/0",
                      busy, bus.mem_arvalid, bus.req_ready, bank_sel);
    end
    next_cyc();
    @(negedge clk);
    total++; if (busy !== 1'b1 || bus.req_ready !== 1'b1 || bus.mem_arvalid !== 1'b0) begin
      bad++; $display("FAIL idle_sw_n2: busy=%0b req_ready=%0b mem_arvalid=%0b want 1/1/0", busy, bus.req_ready, bus.mem_arvalid);
    end
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || bus.mem_arvalid !== 1'b1 || bank_sel !== 3'd2) begin
      bad++; $display("FAIL idle_sw_n3: busy=%0b mem_arvalid=%0b bank_sel=%0d want 0/1/2", busy, bus.mem_arvalid, bank_sel);
    end
    bus.src_arvalid = 1'b0;
  endtask

  task automatic test_drain_reads();
    next_cyc();
    bus.src_arvalid = 1'b1;
    bus.mem_arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.src_arready !== 1'b1) begin bad++; $display("FAIL drain_ar_issue%0d: src_arready=%0b want 1", i, bus.src_arready); end
      next_cyc();
    end
    bus.src_arvalid = 1'b0;
    req_drive(1);
    next_cyc();
    bus.src_arvalid = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_arvalid !== 1'b0 || bus.src_arready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drain_gated: mem_arvalid=%0b src_arready=%0b busy=%0b want 0/0/1", bus.mem_arvalid, bus.src_arready, busy);
    end
    // one non-last beat, then three last beats
    next_cyc();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL drain_wait%0d: req_ready=%0b want 0", i, bus.req_ready); end
      next_cyc();
      bus.rlast = 1'b1;
    end
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL drain_zero_cycle: busy=%0b req_ready=%0b want 1/0", busy, bus.req_ready);
    end
    next_cyc();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bank_sel !== 3'd1) begin
      bad++; $display("FAIL drain_switch: req_ready=%0b bank_sel=%0d want 1/1", bus.req_ready, bank_sel);
    end
    next_cyc();
    bus.req_valid = 1'b0;
    bus.mem_arready = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_arvalid !== 1'b1) begin bad++; $display("FAIL drain_reopen: mem_arvalid=%0b want 1", bus.mem_arvalid); end
    bus.src_arvalid = 1'b0;
  endtask

  task automatic test_outstanding_cap();
    next_cyc();
    bus.src_awvalid = 1'b1;
    bus.mem_awready = 1'b1;
    for (int i = 0; i < MO; i++) begin
      @(negedge clk);
      total++; if (bus.src_awready !== 1'b1 || bus.mem_awvalid !== 1'b1) begin
        bad++; $display("FAIL cap_aw%0d: src_awready=%0b mem_awvalid=%0b want 1/1", i, bus.src_awready, bus.mem_awvalid);
      end
      next_cyc();
    end
    @(negedge clk);
    total++; if (bus.src_awready !== 1'b0 || bus.mem_awvalid !== 1'b0) begin
      bad++; $display("FAIL cap_held: src_awready=%0b mem_awvalid=%0b want 0/0", bus.src_awready, bus.mem_awvalid);
    end
    next_cyc();
    bus.bvalid = 1'b1;
    @(negedge clk);
    total++; if (bus.src_awready !== 1'b0) begin bad++; $display("FAIL cap_b_noready: src_awready=%0b want 0", bus.src_awready); end
    next_cyc();
    bus.bready = 1'b1;
    @(negedge clk);
    total++; if (bus.src_awready !== 1'b0) begin bad++; $display("FAIL cap_b_cycle: src_awready=%0b want 0", bus.src_awready); end
    next_cyc();
    bus.bvalid = 1'b0;
    @(negedge clk);
    total++; if (bus.src_awready !== 1'b1 || bus.mem_awvalid !== 1'b1) begin
      bad++; $display("FAIL cap_fifth: src_awready=%0b mem_awvalid=%0b want 1/1", bus.src_awready, bus.mem_awvalid);
    end
    next_cyc();
    bus.src_awvalid = 1'b0;
    bus.mem_awready = 1'b0;
    bus.bvalid = 1'b1;
    repeat (MO) next_cyc();
    bus.bvalid = 1'b0;
    bus.bready = 1'b0;
  endtask

  task automatic test_same_cycle_and_range();
    next_cyc();
    bus.src_arvalid = 1'b1; bus.mem_arready = 1'b1;
    next_cyc();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    @(negedge clk);
    total++; if (bus.src_arready !== 1'b1) begin bad++; $display("FAIL same_cyc_hs: src_arready=%0b want 1", bus.src_arready); end
    next_cyc();
    bus.src_arvalid = 1'b0; bus.mem_arready = 1'b0;
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    req_drive(3);
    next_cyc();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL same_cyc_m1: busy=%0b req_ready=%0b want 1/0", busy, bus.req_ready);
    end
    next_cyc();
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL same_cyc_m2: busy=%0b req_ready=%0b want 1/0 (rd_cnt should have been 1)", busy, bus.req_ready);
    end
    next_cyc();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bank_sel !== 3'd3) begin
      bad++; $display("FAIL same_cyc_m3: req_ready=%0b bank_sel=%0d want 1/3", bus.req_ready, bank_sel);
    end
    next_cyc();
    bus.req_valid = 1'b0;
    for (int b = 5; b <= 7; b += 2) begin
      next_cyc();
      req_drive(b);
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1 || bus.bank_err !== 1'b1) begin
        bad++; $display("FAIL range_%0d: req_ready=%0b bank_err=%0b want 1/1", b, bus.req_ready, bus.bank_err);
      end
      next_cyc();
      bus.req_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.bank_err !== 1'b0 || bank_sel !== 3'd3 || busy !== 1'b0) begin
        bad++; $display("FAIL range_after_%0d: bank_err=%0b bank_sel=%0d busy=%0b want 0/3/0", b, bus.bank_err, bank_sel, busy);
      end
    end
    // completions with nothing outstanding must not wrap the counters
    next_cyc();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    next_cyc();
    idle_inputs();
    req_drive(0);
    next_cyc();
    next_cyc();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bank_sel !== 3'd0) begin
      bad++; $display("FAIL underflow_switch: req_ready=%0b bank_sel=%0d want 1/0", bus.req_ready, bank_sel);
    end
    next_cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    next_cyc();
    bus.src_arvalid = 1'b1; bus.mem_arready = 1'b1;
    next_cyc();
    bus.src_arvalid = 1'b0; bus.mem_arready = 1'b0;
    req_drive(4);
    next_cyc();
    next_cyc();
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_drain_busy: got %0b want 1", busy); end
    next_cyc();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    sb.delete();
    model_sel = '0;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    total++; if (bank_sel !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_drain_reset: bank_sel=%0d busy=%0b want 0/0", bank_sel, busy);
    end
    next_cyc();
    req_drive(1);
    next_cyc();
    next_cyc();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bank_sel !== 3'd1) begin
      bad++; $display("FAIL mid_drain_cleared: req_ready=%0b bank_sel=%0d want 1/1", bus.req_ready, bank_sel);
    end
    next_cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef DMA_DDR_SWITCH_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    next_cyc();
    bus.src_arvalid = 1'b1; bus.mem_arready = 1'b1;
    next_cyc();
    bus.src_arvalid = 1'b0; bus.mem_arready = 1'b0;
    req_drive(2);
    for (int k = 1; k <= DT; k++) begin
      next_cyc();
      @(negedge clk);
      if (k == DT) begin
        total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %0b want 0", drain_timeout); end
      end
    end
    next_cyc();
    @(negedge clk);
    total++; if (drain_timeout !== exp_to || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_set: drain_timeout=%0b busy=%0b want %0b/1", drain_timeout, busy, exp_to);
    end
    next_cyc();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    next_cyc();
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
    next_cyc();
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bank_sel !== 3'd2 || drain_timeout !== exp_to) begin
      bad++; $display("FAIL timeout_switch: req_ready=%0b bank_sel=%0d drain_timeout=%0b want 1/2/%0b",
                      bus.req_ready, bank_sel, drain_timeout, exp_to);
    end
    next_cyc();
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (drain_timeout !== exp_to || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky: drain_timeout=%0b busy=%0b want %0b/0", drain_timeout, busy, exp_to);
    end
    next_cyc();
    reset = 1'b1;
    model_sel = '0;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    total++; if (drain_timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared: got %0b want 0", drain_timeout); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_sel = '0;
    test_reset();
    test_same_bank();
    test_switch_idle();
    test_drain_reads();
    test_outstanding_cap();
    test_same_cycle_and_range();
    test_reset_mid_drain();
    test_timeout();
    next_cyc();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d requests never accepted, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
